// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline hazard controller that sequences the flush window after a
//            redirect, arbitrates stalls and runs a hold-timeout watchdog.
//            Optional macro PIPE_HAZARD_STAT_EN adds flush/stall cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        bus_wait_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        hold_err_o
`ifdef PIPE_HAZARD_STAT_EN
    ,
    output logic [31:0] flush_cnt_total_o,
    output logic [31:0] stall_cnt_total_o
`endif
);

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_flush = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    localparam logic [2:0] c_flush_load   = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] c_hold_timeout = 8'(HOLD_TIMEOUT);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_flush_cnt;
    logic [2:0] w_flush_cnt_nxt;
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_cnt_nxt;
    logic [7:0] w_hold_cnt_inc;
    logic       r_hold_err;
    logic       w_hold_err_nxt;
    logic       w_run_like;

    logic        w_jump_en;
    logic [31:0] w_jump_addr;
    logic        w_hold_pc;
    logic        w_hold_if_id;
    logic        w_hold_id_ex;
    logic        w_flush_if_id;
    logic        w_flush_id_ex;

    // The HOLD exit cycle (hold_ex_i dropped) arbitrates exactly like RUN.
    assign w_run_like     = (r_state != c_st_flush) && !((r_state == c_st_hold) && hold_ex_i);
    assign w_hold_cnt_inc = (r_hold_cnt == 8'hFF) ? r_hold_cnt : r_hold_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_st_run;
            r_flush_cnt <= 3'd0;
            r_hold_cnt  <= 8'd0;
            r_hold_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_hold_err  <= w_hold_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_hold_err_nxt  = r_hold_err;
        if (w_run_like) begin
            w_state_nxt    = c_st_run;
            w_hold_cnt_nxt = 8'd0;
            if (jump_en_i) begin
                if (FLUSH_CYCLES > 1) begin
                    w_state_nxt     = c_st_flush;
                    w_flush_cnt_nxt = c_flush_load;
                end
            end else if (hold_ex_i) begin
                w_state_nxt    = c_st_hold;
                w_hold_cnt_nxt = 8'd1;
                if (c_hold_timeout <= 8'd1) begin
                    w_hold_err_nxt = 1'b1;
                end
            end
        end else if (r_state == c_st_flush) begin
            // Flush window advances even while the fetch bus stalls.
            if (r_flush_cnt <= 3'd1) begin
                w_state_nxt     = c_st_run;
                w_flush_cnt_nxt = 3'd0;
            end else begin
                w_flush_cnt_nxt = r_flush_cnt - 3'd1;
            end
        end else begin
            w_hold_cnt_nxt = w_hold_cnt_inc;
            if (w_hold_cnt_inc >= c_hold_timeout) begin
                w_hold_err_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        w_jump_en     = 1'b0;
        w_jump_addr   = 32'd0;
        w_hold_pc     = 1'b0;
        w_hold_if_id  = 1'b0;
        w_hold_id_ex  = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        if (r_state == c_st_flush) begin
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            w_hold_pc     = bus_wait_i;
        end else if (!w_run_like) begin
            w_hold_pc    = 1'b1;
            w_hold_if_id = 1'b1;
            w_hold_id_ex = 1'b1;
        end else if (jump_en_i) begin
            w_jump_en     = 1'b1;
            w_jump_addr   = jump_addr_i;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (hold_ex_i) begin
            w_hold_pc    = 1'b1;
            w_hold_if_id = 1'b1;
            w_hold_id_ex = 1'b1;
        end else if (bus_wait_i) begin
            w_hold_pc     = 1'b1;
            w_hold_if_id  = 1'b1;
            w_flush_id_ex = 1'b1;
        end
    end

    assign jump_en_o     = w_jump_en;
    assign jump_addr_o   = w_jump_addr;
    assign hold_pc_o     = w_hold_pc;
    assign hold_if_id_o  = w_hold_if_id & ~w_flush_if_id;
    assign hold_id_ex_o  = w_hold_id_ex & ~w_flush_id_ex;
    assign flush_if_id_o = w_flush_if_id;
    assign flush_id_ex_o = w_flush_id_ex;
    assign hold_err_o    = r_hold_err;

`ifdef PIPE_HAZARD_STAT_EN
    logic [31:0] r_flush_total;
    logic [31:0] r_stall_total;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_total <= 32'd0;
            r_stall_total <= 32'd0;
        end else begin
            r_flush_total <= r_flush_total + {31'd0, w_flush_id_ex};
            r_stall_total <= r_stall_total + {31'd0, w_hold_pc};
        end
    end

    assign flush_cnt_total_o = r_flush_total;
    assign stall_cnt_total_o = r_stall_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench: directed vector table, hand sequences and
//            randomized traffic against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;
    localparam int HT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        hold_ex_i = 1'b0;
    logic        bus_wait_i = 1'b0;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_pc_o, hold_if_id_o, hold_id_ex_o;
    logic        flush_if_id_o, flush_id_ex_o, hold_err_o;
`ifdef PIPE_HAZARD_STAT_EN
    logic [31:0] flush_cnt_total_o, stall_cnt_total_o;
`endif

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_ex_i(hold_ex_i), .bus_wait_i(bus_wait_i),
        .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
        .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .hold_err_o(hold_err_o)
`ifdef PIPE_HAZARD_STAT_EN
        , .flush_cnt_total_o(flush_cnt_total_o), .stall_cnt_total_o(stall_cnt_total_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: cycles of flush left, current hold run length, sticky error.
    int          m_fl, m_hr, n_fl, n_hr;
    bit          m_ih, m_err, n_ih, n_err;
    logic [31:0] m_ft, m_st, n_ft, n_st;

    typedef struct {
        logic        je;
        logic [31:0] addr;
        logic        hex;
        logic        bw;
        logic [38:0] exp;
    } vec_t;
    vec_t vecs[$];

    // Flag order: {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, hold_err}
    function automatic logic [38:0] ex(input logic jo, input logic [31:0] ao, input logic [5:0] f);
        return {jo, ao, f};
    endfunction

    function automatic void add(input logic je, input logic [31:0] a, input logic hex,
                                input logic bw, input logic [38:0] e);
        vec_t v;
        v.je = je; v.addr = a; v.hex = hex; v.bw = bw; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [38:0] got, input logic [38:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got jo=%b addr=%h flags=%b, expected jo=%b addr=%h flags=%b",
                     nm, got[38], got[37:6], got[5:0], exp[38], exp[37:6], exp[5:0]);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fl = 0; m_hr = 0; m_ih = 0; m_err = 0; m_ft = 0; m_st = 0;
    endtask

    task automatic model_eval(input logic je, input logic [31:0] a, input logic hex,
                              input logic bw, output logic [38:0] o);
        logic jo, hpc, hif, hid, fif, fid;
        logic [31:0] ao;
        jo = 0; ao = 0; hpc = 0; hif = 0; hid = 0; fif = 0; fid = 0;
        n_fl = m_fl; n_hr = m_hr; n_ih = m_ih; n_err = m_err;
        if (m_fl > 0) begin
            fif = 1; fid = 1; hpc = bw; n_fl = m_fl - 1;
        end else if (m_ih && hex) begin
            hpc = 1; hif = 1; hid = 1;
            n_hr = (m_hr + 1 > 255) ? 255 : m_hr + 1;
            if (n_hr >= HT) n_err = 1;
        end else begin
            n_ih = 0; n_hr = 0;
            if (je) begin
                jo = 1; ao = a; fif = 1; fid = 1; n_fl = FC - 1;
            end else if (hex) begin
                hpc = 1; hif = 1; hid = 1; n_ih = 1; n_hr = 1;
                if (HT <= 1) n_err = 1;
            end else if (bw) begin
                hpc = 1; hif = 1; fid = 1;
            end
        end
        hif = hif & ~fif;
        hid = hid & ~fid;
        n_ft = m_ft + 32'(fid);
        n_st = m_st + 32'(hpc);
        o = {jo, ao, hpc, hif, hid, fif, fid, m_err};
    endtask

    task automatic step(input logic je, input logic [31:0] a, input logic hex, input logic bw,
                        input string nm, input bit use_exp, input logic [38:0] exp);
        logic [38:0] mexp;
        jump_en_i = je; jump_addr_i = a; hold_ex_i = hex; bus_wait_i = bw;
        @(negedge clk);
        model_eval(je, a, hex, bw, mexp);
        chk(nm, {jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                 flush_if_id_o, flush_id_ex_o, hold_err_o}, use_exp ? exp : mexp);
`ifdef PIPE_HAZARD_STAT_EN
        chk32({nm, "_flush_total"}, flush_cnt_total_o, m_ft);
        chk32({nm, "_stall_total"}, stall_cnt_total_o, m_st);
`endif
        @(posedge clk);
        m_fl = n_fl; m_hr = n_hr; m_ih = n_ih; m_err = n_err; m_ft = n_ft; m_st = n_st;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        jump_en_i = 0; jump_addr_i = 0; hold_ex_i = 0; bus_wait_i = 0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1 rst = 1'b1;
    endtask

    initial begin
        logic hex_lvl;
        // {hpc,hif,hid,fif,fid,err}
        add(0, 32'h0,   0, 0, ex(0, 32'h0,   6'b000000));  // reset state
        add(1, 32'h40,  0, 0, ex(1, 32'h40,  6'b000110));  // redirect
        add(0, 32'h0,   0, 0, ex(0, 32'h0,   6'b000110));  // second flush cycle
        add(0, 32'h0,   0, 0, ex(0, 32'h0,   6'b000000));
        add(0, 32'h0,   1, 0, ex(0, 32'h0,   6'b111000));  // hold entry
        add(0, 32'h0,   1, 0, ex(0, 32'h0,   6'b111000));
        add(0, 32'h0,   1, 0, ex(0, 32'h0,   6'b111000));
        add(0, 32'h0,   0, 0, ex(0, 32'h0,   6'b000000));  // hold exit
        add(1, 32'h80,  1, 1, ex(1, 32'h80,  6'b000110));  // jump beats hold and bus wait
        add(0, 32'h0,   0, 1, ex(0, 32'h0,   6'b100110));  // bus wait inside flush
        add(0, 32'h0,   0, 0, ex(0, 32'h0,   6'b000000));
        add(0, 32'h0,   0, 1, ex(0, 32'h0,   6'b110010));  // bus wait bubble x3
        add(0, 32'h0,   0, 1, ex(0, 32'h0,   6'b110010));
        add(0, 32'h0,   0, 1, ex(0, 32'h0,   6'b110010));
        add(0, 32'h0,   0, 0, ex(0, 32'h0,   6'b000000));
        add(0, 32'h0,   1, 0, ex(0, 32'h0,   6'b111000));
        add(1, 32'h100, 1, 0, ex(0, 32'h0,   6'b111000));  // jump ignored while holding
        add(1, 32'h200, 0, 0, ex(1, 32'h200, 6'b000110));  // exit cycle takes the jump
        add(0, 32'h0,   1, 0, ex(0, 32'h0,   6'b000110));  // hold ignored in flush
        add(0, 32'h0,   0, 0, ex(0, 32'h0,   6'b000000));

        do_reset();
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].je, vecs[i].addr, vecs[i].hex, vecs[i].bw,
                 $sformatf("vec%0d", i), 1'b1, vecs[i].exp);

        // Watchdog: error visible after the 4th hold cycle, sticky until reset.
        do_reset();
        for (int i = 1; i <= 10; i++)
            step(0, 0, 1, 0, $sformatf("wd_hold%0d", i), 1'b1,
                 ex(0, 0, (i <= HT) ? 6'b111000 : 6'b111001));
        step(0, 0, 0, 0, "wd_sticky_idle", 1'b1, ex(0, 0, 6'b000001));
        step(0, 0, 0, 1, "wd_sticky_bw",   1'b1, ex(0, 0, 6'b110011));
        do_reset();
        step(0, 0, 0, 0, "wd_cleared", 1'b1, ex(0, 0, 6'b000000));

`ifdef PIPE_HAZARD_STAT_EN
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, $sformatf("stat_bw%0d", i), 1'b0, '0);
        @(negedge clk);
        chk32("stat_stall_3", stall_cnt_total_o, 32'd3);
        chk32("stat_flush_3", flush_cnt_total_o, 32'd3);
        @(posedge clk); #1;
`endif

        // Randomized traffic with a sticky hold level so timeouts are reached.
        do_reset();
        hex_lvl = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                rst = 1'b0;
                jump_en_i = 1'($urandom); hold_ex_i = 1'($urandom); bus_wait_i = 1'($urandom);
                @(posedge clk);
                model_reset();
                #1 rst = 1'b1;
            end else begin
                if ($urandom_range(0, 4) == 0) hex_lvl = ~hex_lvl;
                step(($urandom_range(0, 99) < 15), $urandom, hex_lvl,
                     ($urandom_range(0, 99) < 30), $sformatf("rnd%0d", i), 1'b0, '0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller between the execute stage and the pc_reg / if_id / id_ex registers.
- Takes branch/jump redirects and hold requests from the execute stage, plus fetch-bus wait from the instruction bus.
- Sequences multi-cycle flush windows after a redirect and arbitrates stall sources.
- Drives per-stage hold and flush controls, with a hold-timeout watchdog.

Parameters:
- FLUSH_CYCLES, 2: cycles to flush if_id and id_ex after an accepted redirect, including the redirect cycle; legal range 1..7.
- HOLD_TIMEOUT, 255: maximum consecutive ex-hold cycles before the watchdog flags an error; legal range 1..255.

Ports:
- clk  input  1  core clock
- rst  input  1  reset; synchronous, active-low
- jump_en_i  input  1  redirect request from execute stage (combinational)
- jump_addr_i  input  32  redirect target
- hold_ex_i  input  1  execute-stage hold request (multi-cycle op), level
- bus_wait_i  input  1  instruction bus not ready, level
- jump_en_o  output  1  redirect strobe to pc_reg
- jump_addr_o  output  32  redirect target to pc_reg
- hold_pc_o  output  1  freeze pc_reg
- hold_if_id_o  output  1  freeze if_id
- hold_id_ex_o  output  1  freeze id_ex
- flush_if_id_o  output  1  load NOP into if_id
- flush_id_ex_o  output  1  load NOP into id_ex
- hold_err_o  output  1  sticky watchdog error

Behaviour:
- Reset (rst==0 at a clk edge): state RUN; flush_cnt=0; hold_cnt=0; hold_err_o=0. Every output is 0 while in RESET-derived RUN with all inputs low.
- States: RUN, FLUSH, HOLD.
- Output generation:
  - Outputs are combinational from state and inputs.
  - Counters and state update on the rising edge of clk.
- Priority in RUN, same cycle:
  - 1) jump_en_i.
  - 2) hold_ex_i.
  - 3) bus_wait_i.
  - Lower-priority requests present in that cycle are ignored.
- RUN, jump_en_i=1:
  - Drive jump_en_o=1 and jump_addr_o=jump_addr_i in the same cycle (zero latency).
  - Drive flush_if_id_o=1 and flush_id_ex_o=1.
  - If FLUSH_CYCLES>1: go to FLUSH with flush_cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- FLUSH:
  - Drive flush_if_id_o=1 and flush_id_ex_o=1.
  - Drive jump_en_o=0 and jump_addr_o=0.
  - flush_cnt decrements each cycle; on flush_cnt==1, return to RUN.
  - jump_en_i and hold_ex_i are ignored: execute holds a bubble.
  - bus_wait_i=1 additionally drives hold_pc_o=1, but the flush count still advances.
- RUN, hold_ex_i=1 (no jump):
  - Drive hold_pc_o=hold_if_id_o=hold_id_ex_o=1.
  - Go to HOLD with hold_cnt=1.
- HOLD:
  - While hold_ex_i=1: all three holds stay at 1 and hold_cnt increments, saturating at 255.
  - When hold_cnt reaches HOLD_TIMEOUT with hold_ex_i still 1: set hold_err_o=1 (sticky until reset). Holds remain asserted.
  - When hold_ex_i=0: holds deassert in the same cycle, hold_cnt clears, return to RUN.
  - In that same cycle, jump_en_i=1 is processed as in RUN, i.e. the exit cycle behaves as RUN.
- RUN, bus_wait_i=1 only:
  - Drive hold_pc_o=1, hold_if_id_o=1 and flush_id_ex_o=1 (bubble into execute).
  - No state change.
- Flush vs hold on the same register: flush wins; hold_x_o is forced to 0 whenever flush_x_o=1.
- jump_addr_o is 0 whenever jump_en_o=0.
- rst=0 in any state, mid-flush or mid-hold: return to RUN next edge. Counters clear and hold_err_o clears.

Optional Feature:
- Macro PIPE_HAZARD_STAT_EN.
- Defined:
  - Adds output ports flush_cnt_total_o[31:0] and stall_cnt_total_o[31:0].
  - flush_cnt_total_o counts cycles with flush_id_ex_o=1.
  - stall_cnt_total_o counts cycles with hold_pc_o=1.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: the ports and counters are absent, with no other behaviour difference.

Test Plan:
- Reset with rst=0 for 2 cycles, all inputs 0, then release -> all outputs 0; state RUN.
- RUN, 1-cycle pulse jump_en_i=1 with jump_addr_i=32'h0000_0040, FLUSH_CYCLES=2 ->
  - cycle 0: jump_en_o=1, jump_addr_o=32'h40, both flushes=1.
  - cycle 1: both flushes=1, jump_en_o=0.
  - cycle 2: all outputs 0.
- hold_ex_i=1 for 5 cycles, then 0 -> hold_pc_o/hold_if_id_o/hold_id_ex_o=1 for exactly 5 cycles and 0 in cycle 6; hold_err_o=0.
- HOLD_TIMEOUT=4, hold_ex_i=1 for 10 cycles -> hold_err_o rises after the 4th hold cycle; it stays 1 after hold_ex_i drops; it clears only on rst=0.
- Same cycle jump_en_i=1, hold_ex_i=1, bus_wait_i=1 in RUN -> jump accepted; flushes=1; all holds=0; FLUSH entered. Then bus_wait_i=1 during FLUSH -> hold_pc_o=1 and flushes continue for 2 cycles total.
- bus_wait_i=1 for 3 cycles in RUN -> hold_pc_o=hold_if_id_o=1 and flush_id_ex_o=1 for 3 cycles. With PIPE_HAZARD_STAT_EN defined, stall_cnt_total_o=3 and flush_cnt_total_o=3.
